store_outstanding_ctrl: RTL

- Admission controller for the store path between the store unit and the write-through data cache.
- Counts stores issued to memory but not yet acknowledged, and stops new stores at MaxOutstandingStores (7).
- Sequences fence drains: blocks new stores, waits for count zero and an empty write buffer, then signals completion.
- Sits between the store unit issue handshake and the cache/NoC acknowledge path.

---
 rtl/store_ctrl_pkg.sv | 21 ++
 rtl/updown_sat_counter.sv | 50 +++++
 rtl/store_outstanding_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/store_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : store_ctrl_pkg
// Brief   : Shared types and helpers for the store admission controller.
// Revision: 1.0 - initial release
// ============================================================================
package store_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } store_fence_state_e;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/updown_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : updown_sat_counter
// Brief   : Up/down counter saturating at 0 and MAX_VAL with limit strobes.
// Revision: 1.0 - initial release
// ============================================================================
module updown_sat_counter
    import store_ctrl_pkg::*;
#(
    parameter int MAX_VAL = 7,
    parameter int WIDTH   = cnt_width(MAX_VAL)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_underflow,
    output logic             o_overflow
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             w_up;
    logic             w_down;

    // Simultaneous inc and dec cancel out and never hit a limit.
    assign w_up        = i_inc & ~i_dec & ~i_clr;
    assign w_down      = i_dec & ~i_inc & ~i_clr;
    assign o_overflow  = w_up & (r_count == c_MAX);
    assign o_underflow = w_down & (r_count == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (w_up && !o_overflow) begin
            r_count <= r_count + WIDTH'(1);
        end else if (w_down && !o_underflow) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/store_outstanding_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : store_outstanding_ctrl
// Brief   : Limits in-flight stores and sequences fence drains.
// Revision: 1.0 - initial release
// ============================================================================
module store_outstanding_ctrl
    import store_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING_STORES = 7,
    parameter int CNT_WIDTH              = cnt_width(MAX_OUTSTANDING_STORES),
    parameter int DRAIN_TIMEOUT          = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 st_req_i,
    output logic                 st_gnt_o,
    input  logic                 st_ack_i,
    input  logic                 fence_req_i,
    input  logic                 wbuf_empty_i,
    output logic                 fence_done_o,
    output logic [CNT_WIDTH-1:0] outstanding_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 underflow_o,
    output logic                 timeout_o
);

    localparam logic [1:0] c_S_IDLE  = IDLE;
    localparam logic [1:0] c_S_DRAIN = DRAIN;
    localparam logic [1:0] c_S_DONE  = DONE;

    localparam int                   c_TMR_MAX  = (DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT : 1;
    localparam int                   c_TMR_W    = cnt_width(c_TMR_MAX);
    localparam logic [c_TMR_W-1:0]   c_TMR_LAST = c_TMR_W'(c_TMR_MAX - 1);
    localparam logic                 c_TMR_EN   = (DRAIN_TIMEOUT > 0);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING_STORES);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_underflow;
    logic                 r_timeout;
    logic                 w_in_idle;
    logic                 w_in_drain;
    logic                 w_gnt;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_WIDTH-1:0] w_count;
    logic                 w_cnt_udf;
    logic                 w_cnt_ovf;
    logic [c_TMR_W-1:0]   w_tmr;
    logic                 w_tmr_udf;
    logic                 w_tmr_ovf;
    logic                 w_unused;

    assign w_in_idle  = (r_state == c_S_IDLE);
    assign w_in_drain = (r_state == c_S_DRAIN);
    assign w_full     = (w_count == c_CNT_MAX);
    assign w_empty    = (w_count == '0);

    // A pending fence outranks a store in the same cycle; acks never feed the grant.
    assign w_gnt = st_req_i & ~w_full & w_in_idle & ~fence_req_i;

    updown_sat_counter #(
        .MAX_VAL (MAX_OUTSTANDING_STORES),
        .WIDTH   (CNT_WIDTH)
    ) u_inflight (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_clr       (1'b0),
        .i_inc       (w_gnt),
        .i_dec       (st_ack_i),
        .o_count     (w_count),
        .o_underflow (w_cnt_udf),
        .o_overflow  (w_cnt_ovf)
    );

    // Held at zero outside DRAIN, so each drain starts counting from zero.
    updown_sat_counter #(
        .MAX_VAL (c_TMR_MAX),
        .WIDTH   (c_TMR_W)
    ) u_drain_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_clr       (~w_in_drain),
        .i_inc       (w_in_drain),
        .i_dec       (1'b0),
        .o_count     (w_tmr),
        .o_underflow (w_tmr_udf),
        .o_overflow  (w_tmr_ovf)
    );

    assign w_unused = ^{w_tmr_udf, w_tmr_ovf};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (fence_req_i && !flush_i) w_state_nxt = c_S_DRAIN;
            end
            c_S_DRAIN: begin
                if (flush_i)                      w_state_nxt = c_S_IDLE;
                else if (w_empty && wbuf_empty_i) w_state_nxt = c_S_DONE;
            end
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= c_S_IDLE;
            r_underflow <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_underflow <= r_underflow | w_cnt_udf;
            // Flag lands on the same edge the timer reaches the limit.
            r_timeout   <= r_timeout | (c_TMR_EN & w_in_drain & (w_tmr >= c_TMR_LAST));
        end
    end

    a_no_cnt_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !w_cnt_ovf);

    assign st_gnt_o      = w_gnt;
    assign fence_done_o  = (r_state == c_S_DONE);
    assign outstanding_o = w_count;
    assign full_o        = w_full;
    assign empty_o       = w_empty;
    assign underflow_o   = r_underflow;
    assign timeout_o     = r_timeout;

endmodule
`default_nettype wire
